// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcode constants,
// FSM state enumeration and datapath select encodings.
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the HALT state.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;

  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;

endpackage

// File: rtl/instrdec.sv
// Immediate-format decoder: purely combinational op -> ImmSrc.
// Ports: op (opcode field), ImmSrc (immediate format select).
module instrdec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core. Moore outputs decoded from
// the state register; PCWrite/IRWrite additionally qualified by Zero/mem_ready.
// Ports: clk, rst_n (sync, active-low), op, Zero, mem_ready in; PCWrite,
// AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
// ImmSrc out; illegal out only when MC_ILLEGAL_TRAP_EN is defined.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic     illegal
`endif
);

  state_e state_q, state_d, cur;
  logic   pc_update, branch, ir_write, mem_write, reg_write;

  instrdec u_instrdec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs show FETCH values, so decode from a
  // reset-overridden state and additionally mask the write enables below.
  always_comb begin
    cur       = rst_n ? state_q : S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal   = 1'b0;
`endif
    case (cur)
      S_FETCH: begin
        ResultSrc = RES_ALURESULT;
        ALUSrcB   = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:     illegal = 1'b1;
`endif
      default: ;
    endcase
    PCWrite  = rst_n & (pc_update | (branch & Zero));
    IRWrite  = rst_n & ir_write;
    MemWrite = rst_n & mem_write;
    RegWrite = rst_n & reg_write;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Expected outputs come from an
// instruction-level model: each opcode expands into its list of steps, with
// memory stalls inserted as repeated steps. Honors MC_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n, Zero, mem_ready;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [12:0] outs;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
  logic       exp_ill = 1'b0;
`endif

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal (illegal)
`endif
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  function automatic logic [12:0] ov(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop);
    return {pcw, adr, mw, irw, rw, rs, a, b, aop};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == LW || o == IT) return 2'b00;
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected output words per instruction step
  logic [12:0] F_WAIT, F_GO, DEC, MADR, MRD, MWR, MWB, EXR, EXI, AWB, JAL_S;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // One clock: drive, sample at the falling edge, advance past the rising edge.
  task automatic step(input string tag, input logic mr, input logic z, input logic [12:0] exp);
    mem_ready = mr;
    Zero      = z;
    @(negedge clk);
    chk(tag, outs, exp);
    chk({tag, "/imm"}, {11'b0, ImmSrc}, {11'b0, imm_of(op)});
`ifdef MC_ILLEGAL_TRAP_EN
    chk({tag, "/ill"}, {12'b0, illegal}, {12'b0, exp_ill});
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input int unsigned fst,
                           input int unsigned mst, input logic z);
    op = o;
    for (int unsigned i = 0; i < fst; i++) step("fetch_wait", 1'b0, rb(), F_WAIT);
    step("fetch", 1'b1, rb(), F_GO);
    step("decode", rb(), rb(), DEC);
    case (o)
      LW: begin
        step("memadr_lw", rb(), rb(), MADR);
        for (int unsigned i = 0; i < mst; i++) step("memread_wait", 1'b0, rb(), MRD);
        step("memread", 1'b1, rb(), MRD);
        step("memwb", rb(), rb(), MWB);
      end
      SW: begin
        step("memadr_sw", rb(), rb(), MADR);
        for (int unsigned i = 0; i < mst; i++) step("memwrite_wait", 1'b0, rb(), MWR);
        step("memwrite", 1'b1, rb(), MWR);
      end
      RT: begin
        step("exec_r", rb(), rb(), EXR);
        step("aluwb_r", rb(), rb(), AWB);
      end
      IT: begin
        step("exec_i", rb(), rb(), EXI);
        step("aluwb_i", rb(), rb(), AWB);
      end
      BQ: step("beq", rb(), z, ov(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01));
      JL: begin
        step("jal", rb(), rb(), JAL_S);
        step("aluwb_jal", rb(), rb(), AWB);
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        for (int unsigned i = 0; i < 4; i++) step("halt", rb(), rb(), 13'h0);
`endif
      end
    endcase
  endtask

  initial begin
    F_WAIT = ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    F_GO   = ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    DEC    = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    MADR   = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    MRD    = ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    MWR    = ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    MWB    = ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    EXR    = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    EXI    = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
    AWB    = ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    JAL_S  = ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);

    rst_n = 1'b0; op = RT; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset held with mem_ready=1: FETCH values, enables masked
    step("reset0", 1'b1, 1'b1, F_WAIT);
    step("reset1", 1'b1, 1'b0, F_WAIT);
    rst_n = 1'b1;

    // Directed sequences from the test plan
    run_instr(RT, 0, 0, 1'b0);
    run_instr(LW, 0, 2, 1'b0);
    run_instr(SW, 0, 1, 1'b0);
    run_instr(BQ, 0, 0, 1'b1);
    run_instr(BQ, 0, 0, 1'b0);
    run_instr(JL, 0, 0, 1'b0);
    run_instr(IT, 2, 0, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
    run_instr(BAD, 1, 0, 1'b0);
`endif

    // Reset asserted mid-MEMWRITE: MemWrite drops combinationally
    op = SW;
    step("rw_fetch", 1'b1, 1'b0, F_GO);
    step("rw_decode", 1'b1, 1'b0, DEC);
    step("rw_memadr", 1'b1, 1'b0, MADR);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rw_memwrite", outs, MWR);
    rst_n = 1'b0;
    #1;
    chk("rw_reset_drop", outs, F_WAIT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(RT, 1, 0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      int unsigned k;
      k = $urandom_range(0, 7);
      case (k)
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BQ;
        5: o = JL;
`ifdef MC_ILLEGAL_TRAP_EN
        default: o = RT;
`else
        6: o = 7'b0110111;
        default: o = BAD;
`endif
      endcase
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

`ifdef MC_ILLEGAL_TRAP_EN
    // Unknown opcode halts until reset
    run_instr(BAD, 0, 0, 1'b0);
    rst_n = 1'b0;
    exp_ill = 1'b0;
    step("halt_reset", 1'b1, 1'b0, F_WAIT);
    rst_n = 1'b1;
    run_instr(LW, 0, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
